// File: rtl/video_timing_pkg.sv
// Video timing generator shared definitions: mode encodings, per-mode
// timing records and the mode-to-timing lookup.
package video_timing_pkg;

    localparam int unsigned HCNT_W = 11;
    localparam int unsigned VCNT_W = 10;

    typedef enum logic [1:0] {
        MODE_NTSC = 2'd0,
        MODE_PAL  = 2'd1,
        MODE_MONO = 2'd2,
        MODE_RSVD = 2'd3
    } vtg_mode_t;

    typedef struct packed {
        logic [HCNT_W-1:0] h_total;
        logic [HCNT_W-1:0] h_act;
        logic [HCNT_W-1:0] h_fp;
        logic [HCNT_W-1:0] h_sw;
        logic [VCNT_W-1:0] v_total;
        logic [VCNT_W-1:0] v_act;
        logic [VCNT_W-1:0] v_fp;
        logic [VCNT_W-1:0] v_sw;
    } vtg_timing_t;

    localparam vtg_timing_t TIMING_PAL = '{
        h_total: 11'd864, h_act: 11'd720, h_fp: 11'd12, h_sw: 11'd64,
        v_total: 10'd625, v_act: 10'd576, v_fp: 10'd5,  v_sw: 10'd5
    };

    localparam vtg_timing_t TIMING_NTSC = '{
        h_total: 11'd858, h_act: 11'd720, h_fp: 11'd16, h_sw: 11'd62,
        v_total: 10'd525, v_act: 10'd480, v_fp: 10'd9,  v_sw: 10'd6
    };

    localparam vtg_timing_t TIMING_MONO = '{
        h_total: 11'd800, h_act: 11'd640, h_fp: 11'd16, h_sw: 11'd96,
        v_total: 10'd525, v_act: 10'd480, v_fp: 10'd10, v_sw: 10'd2
    };

    // Reserved code falls back to PAL timing.
    function automatic vtg_timing_t mode_timing(input vtg_mode_t m);
        vtg_timing_t t;
        case (m)
            MODE_NTSC: t = TIMING_NTSC;
            MODE_MONO: t = TIMING_MONO;
            default:   t = TIMING_PAL;
        endcase
        return t;
    endfunction

    // Line the vertical counter parks on after reset: first blanking line.
    function automatic logic [VCNT_W-1:0] reset_vcnt(input vtg_mode_t m);
        vtg_timing_t t;
        t = mode_timing(m);
        return t.v_act;
    endfunction

endpackage

// File: rtl/vtg_counter.sv
// Horizontal/vertical position counter pair with line/frame wrap,
// load-to-zero and a frame-wrap strobe.
module vtg_counter
    import video_timing_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load_zero,
    input  logic [HCNT_W-1:0] i_h_total,
    input  logic [VCNT_W-1:0] i_v_total,
    input  logic [VCNT_W-1:0] i_v_reset_val,
    output logic [HCNT_W-1:0] o_hcnt,
    output logic [VCNT_W-1:0] o_vcnt,
    output logic              o_frame_end
);

    logic [HCNT_W-1:0] r_hcnt;
    logic [VCNT_W-1:0] r_vcnt;
    logic              w_line_end;
    logic              w_frame_end;

    assign w_line_end  = (r_hcnt == (i_h_total - 11'd1));
    assign w_frame_end = w_line_end && (r_vcnt == (i_v_total - 10'd1));

    // Advance position; load-to-zero and natural frame wrap land on (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcnt <= '0;
            r_vcnt <= i_v_reset_val;
        end else if (i_load_zero || w_frame_end) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_line_end) begin
            r_hcnt <= '0;
            r_vcnt <= r_vcnt + 10'd1;
        end else begin
            r_hcnt <= r_hcnt + 11'd1;
        end
    end

    assign o_hcnt      = r_hcnt;
    assign o_vcnt      = r_vcnt;
    assign o_frame_end = w_frame_end;

endmodule

// File: rtl/video_timing_gen.sv
// Free-running PAL/NTSC/mono video timing generator with vreset realignment.
// Optional lock detector built when VTG_LOCK_DETECT_EN is defined.
module video_timing_gen
    import video_timing_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              vreset,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic [HCNT_W-1:0] x,
    output logic [VCNT_W-1:0] y,
    output logic              sof
`ifdef VTG_LOCK_DETECT_EN
    ,
    output logic              locked
`endif
);

    vtg_mode_t         r_cur_mode;
    vtg_mode_t         w_mode_in;
    vtg_timing_t       w_tim;
    logic [HCNT_W-1:0] w_hcnt;
    logic [VCNT_W-1:0] w_vcnt;
    logic              w_frame_end;
    logic              w_resample;
    logic [HCNT_W-1:0] w_hs_start;
    logic [HCNT_W-1:0] w_hs_end;
    logic [VCNT_W-1:0] w_vs_start;
    logic [VCNT_W-1:0] w_vs_end;
    logic              w_de;
    logic              w_hs_n;
    logic              w_vs_n;
    logic              w_sof;

    assign w_mode_in  = vtg_mode_t'(mode);
    assign w_tim      = mode_timing(r_cur_mode);
    // Mode is only taken at a frame boundary, so counters and decode
    // switch timing set on the same edge that lands on (0,0).
    assign w_resample = vreset || w_frame_end;

    vtg_counter u_counter (
        .clk           (clk),
        .reset         (reset),
        .i_load_zero   (vreset),
        .i_h_total     (w_tim.h_total),
        .i_v_total     (w_tim.v_total),
        .i_v_reset_val (reset_vcnt(w_mode_in)),
        .o_hcnt        (w_hcnt),
        .o_vcnt        (w_vcnt),
        .o_frame_end   (w_frame_end)
    );

    // Latch the operating mode at reset, vreset or natural frame wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_mode <= w_mode_in;
        end else if (w_resample) begin
            r_cur_mode <= w_mode_in;
        end
    end

    // Decode sync windows and active area from the current position.
    always_comb begin
        w_hs_start = w_tim.h_act + w_tim.h_fp;
        w_hs_end   = w_hs_start + w_tim.h_sw;
        w_vs_start = w_tim.v_act + w_tim.v_fp;
        w_vs_end   = w_vs_start + w_tim.v_sw;
        w_de       = (w_hcnt < w_tim.h_act) && (w_vcnt < w_tim.v_act);
        w_hs_n     = !((w_hcnt >= w_hs_start) && (w_hcnt < w_hs_end));
        w_vs_n     = !((w_vcnt >= w_vs_start) && (w_vcnt < w_vs_end));
        w_sof      = (w_hcnt == '0) && (w_vcnt == '0);
    end

    // Register all video outputs; coordinates are zeroed outside de.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs  <= 1'b1;
            vs  <= 1'b1;
            de  <= 1'b0;
            x   <= '0;
            y   <= '0;
            sof <= 1'b0;
        end else begin
            hs  <= w_hs_n;
            vs  <= w_vs_n;
            de  <= w_de;
            x   <= w_de ? w_hcnt : '0;
            y   <= w_de ? w_vcnt : '0;
            sof <= w_sof;
        end
    end

`ifdef VTG_LOCK_DETECT_EN
    logic r_locked;

    // Lock when vreset coincides with the natural wrap; any mode change wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_locked <= 1'b0;
        end else if (w_resample && (w_mode_in != r_cur_mode)) begin
            r_locked <= 1'b0;
        end else if (vreset) begin
            r_locked <= w_frame_end;
        end
    end

    assign locked = r_locked;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: scenario tasks plus a
// frame-position reference model compared every cycle.
module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        vreset;
    logic        hs, vs, de, sof;
    logic [10:0] x;
    logic [9:0]  y;
`ifdef VTG_LOCK_DETECT_EN
    logic        locked;
`endif

    video_timing_gen dut (
        .clk    (clk),
        .reset  (reset),
        .mode   (mode),
        .vreset (vreset),
        .hs     (hs),
        .vs     (vs),
        .de     (de),
        .x      (x),
        .y      (y),
        .sof    (sof)
`ifdef VTG_LOCK_DETECT_EN
        ,
        .locked (locked)
`endif
    );

    always #5 clk = ~clk;

    // Timing tables indexed by raw mode code (3 behaves as PAL).
    int HT [4] = '{858, 864, 800, 864};
    int HA [4] = '{720, 720, 640, 720};
    int HF [4] = '{16,  12,  16,  12};
    int HS [4] = '{62,  64,  96,  64};
    int VT [4] = '{525, 625, 525, 625};
    int VA [4] = '{480, 576, 480, 576};
    int VF [4] = '{9,   5,   10,  5};
    int VS [4] = '{6,   5,   2,   5};

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    // Reference model: linear position within the frame.
    int          m_pos = 0;
    logic [1:0]  m_raw = 2'd1;
    logic [24:0] e_vec = '0;
    logic        e_lock = 1'b0;
    logic [24:0] a_vec;

    int          cyc_diff = 0;
    int          d_cyc = 0;
    logic [24:0] d_act, d_exp;

    assign a_vec = {hs, vs, de, sof, x, y};

    function automatic logic [24:0] decode(input int pos, input logic [1:0] m);
        int   h, v, hs0, vs0;
        logic d;
        h   = pos % HT[m];
        v   = pos / HT[m];
        hs0 = HA[m] + HF[m];
        vs0 = VA[m] + VF[m];
        d   = (h < HA[m]) && (v < VA[m]);
        return {!(h >= hs0 && h < hs0 + HS[m]), !(v >= vs0 && v < vs0 + VS[m]),
                d, (pos == 0), d ? 11'(h) : 11'd0, d ? 10'(v) : 10'd0};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            e_vec  <= {1'b1, 1'b1, 1'b0, 1'b0, 21'd0};
            m_raw  <= mode;
            m_pos  <= VA[mode] * HT[mode];
            e_lock <= 1'b0;
        end else begin
            e_vec <= decode(m_pos, m_raw);
            if (vreset || m_pos == HT[m_raw] * VT[m_raw] - 1) begin
                m_pos <= 0;
                m_raw <= mode;
            end else begin
                m_pos <= m_pos + 1;
            end
            if ((vreset || m_pos == HT[m_raw] * VT[m_raw] - 1) && mode != m_raw)
                e_lock <= 1'b0;
            else if (vreset)
                e_lock <= (m_pos == HT[m_raw] * VT[m_raw] - 1);
        end
    end

    // Advance one clock and tally any divergence from the model.
    task automatic tick();
        logic diff;
        @(posedge clk);
        #1;
        ncyc++;
        diff = (a_vec !== e_vec);
`ifdef VTG_LOCK_DETECT_EN
        if (locked !== e_lock) diff = 1'b1;
`endif
        if (diff) begin
            if (cyc_diff == 0) begin
                d_cyc = ncyc;
                d_act = a_vec;
                d_exp = e_vec;
            end
            cyc_diff++;
        end
    endtask

    // Measure one full active line: period, de width, front porch, sync width.
    task automatic measure_line(output int period, output int de_w, output int fp, output int sw);
        int   t0, tdf, thf, thr, t1, n;
        logic pde, phs;
        period = -1; de_w = -1; fp = -1; sw = -1;
        t0 = -1; tdf = -1; thf = -1; thr = -1; t1 = -1; n = 0;
        pde = de;
        while (n < 3000 && t0 < 0) begin
            tick(); n++;
            if (de && !pde) t0 = ncyc;
            pde = de;
        end
        if (t0 < 0) return;
        phs = hs;
        while (n < 6000 && t1 < 0) begin
            tick(); n++;
            if (!de && pde && tdf < 0) tdf = ncyc;
            if (!hs && phs && thf < 0) thf = ncyc;
            if (hs && !phs && thf >= 0 && thr < 0) thr = ncyc;
            if (de && !pde) t1 = ncyc;
            pde = de;
            phs = hs;
        end
        if (t1 < 0 || thr < 0) return;
        period = t1 - t0; de_w = tdf - t0; fp = thf - tdf; sw = thr - thf;
    endtask

    task automatic test_reset();
        int sof_at, vs_first, vs_low;
        cyc_diff = 0;
        mode = 2'd1; vreset = 1'b0; reset = 1'b1;
        repeat (5) tick();
        total++;
        if (a_vec !== {1'b1, 1'b1, 1'b0, 1'b0, 21'd0}) begin
            bad++; $display("FAIL reset_state: got %h expected %h", a_vec, {1'b1, 1'b1, 1'b0, 1'b0, 21'd0});
        end
        reset = 1'b0;
        sof_at = -1; vs_first = -1; vs_low = 0;
        // vreset placed on the exact natural wrap edge must not disturb anything
        for (int n = 1; n <= 50000 && sof_at < 0; n++) begin
            tick();
            vreset = (n == 49 * 864 - 1);
            if (!vs) begin
                vs_low++;
                if (vs_first < 0) vs_first = n;
            end
            if (sof) sof_at = n;
        end
        vreset = 1'b0;
        total++;
        if (sof_at !== 49 * 864 + 1) begin
            bad++; $display("FAIL first_sof: got %0d expected %0d", sof_at, 49 * 864 + 1);
        end
        total++;
        if (vs_first !== 5 * 864 + 1) begin
            bad++; $display("FAIL vs_start: got %0d expected %0d", vs_first, 5 * 864 + 1);
        end
        total++;
        if (vs_low !== 5 * 864) begin
            bad++; $display("FAIL vs_width: got %0d expected %0d", vs_low, 5 * 864);
        end
`ifdef VTG_LOCK_DETECT_EN
        total++;
        if (locked !== 1'b1) begin
            bad++; $display("FAIL lock_on_wrap: got %b expected 1", locked);
        end
`endif
        total++;
        if (cyc_diff !== 0) begin
            bad++; $display("FAIL model_reset: %0d cycles differ, first at %0d got %h expected %h", cyc_diff, d_cyc, d_act, d_exp);
        end
    endtask

    task automatic test_vreset_mid();
        int   n;
        logic pde;
        cyc_diff = 0;
        // counters now at (1,0); move to (300,3)
        repeat (3 * 864 + 299) tick();
        vreset = 1'b1;
        tick();
        vreset = 1'b0;
        total++;
        if ({de, x, y} !== {1'b1, 11'd300, 10'd3}) begin
            bad++; $display("FAIL pre_vreset_pos: got %b/%0d/%0d expected 1/300/3", de, x, y);
        end
`ifdef VTG_LOCK_DETECT_EN
        total++;
        if (locked !== 1'b0) begin
            bad++; $display("FAIL lock_clear: got %b expected 0", locked);
        end
`endif
        tick();
        total++;
        if ({de, sof} !== 2'b11) begin
            bad++; $display("FAIL vreset_sof: got de=%b sof=%b expected 1 1", de, sof);
        end
        total++;
        if ({x, y} !== 21'd0) begin
            bad++; $display("FAIL vreset_xy: got %0d,%0d expected 0,0", x, y);
        end
        n = 0; pde = 1'b1;
        while (n < 2000) begin
            tick(); n++;
            if (de && !pde) break;
            pde = de;
        end
        total++;
        if (n !== 864) begin
            bad++; $display("FAIL line_after_vreset: got %0d expected 864", n);
        end
        total++;
        if (cyc_diff !== 0) begin
            bad++; $display("FAIL model_vreset: %0d cycles differ, first at %0d got %h expected %h", cyc_diff, d_cyc, d_act, d_exp);
        end
    endtask

    task automatic test_mode_switch();
        int p, d, f, s;
        cyc_diff = 0;
        mode = 2'd0;
        for (int i = 0; i < 2; i++) begin
            measure_line(p, d, f, s);
            total++;
            if (p !== 864 || d !== 720) begin
                bad++; $display("FAIL pal_line_after_switch: got period %0d de %0d expected 864 720", p, d);
            end
        end
        vreset = 1'b1;
        tick();
        vreset = 1'b0;
        measure_line(p, d, f, s);
        total++;
        if (p !== 858) begin
            bad++; $display("FAIL ntsc_period: got %0d expected 858", p);
        end
        total++;
        if (d !== 720) begin
            bad++; $display("FAIL ntsc_de: got %0d expected 720", d);
        end
        total++;
        if (f !== 16 || s !== 62) begin
            bad++; $display("FAIL ntsc_hsync: got fp %0d sw %0d expected 16 62", f, s);
        end
        total++;
        if (cyc_diff !== 0) begin
            bad++; $display("FAIL model_switch: %0d cycles differ, first at %0d got %h expected %h", cyc_diff, d_cyc, d_act, d_exp);
        end
    endtask

    task automatic test_mono_reset();
        int   sof_cnt, vs_first, vs_low, last_hf, hs_int, p, d, f, s;
        logic phs;
        cyc_diff = 0;
        mode = 2'd2; reset = 1'b1; vreset = 1'b1;
        tick();
        vreset = 1'b0;
        tick(); tick();
        total++;
        if (a_vec !== {1'b1, 1'b1, 1'b0, 1'b0, 21'd0}) begin
            bad++; $display("FAIL reset_vreset_state: got %h", a_vec);
        end
        reset = 1'b0;
        sof_cnt = 0; vs_first = -1; vs_low = 0; last_hf = -1; hs_int = -1; phs = hs;
        for (int n = 1; n <= 12 * 800; n++) begin
            tick();
            if (sof) sof_cnt++;
            if (!vs) begin
                vs_low++;
                if (vs_first < 0) vs_first = n;
            end
            if (!hs && phs) begin
                if (last_hf >= 0) hs_int = n - last_hf;
                last_hf = n;
            end
            phs = hs;
        end
        total++;
        if (sof_cnt !== 0) begin
            bad++; $display("FAIL no_sof_after_reset: got %0d pulses expected 0", sof_cnt);
        end
        total++;
        if (vs_first !== 10 * 800 + 1 || vs_low !== 2 * 800) begin
            bad++; $display("FAIL mono_vs: got start %0d width %0d expected %0d %0d", vs_first, vs_low, 10 * 800 + 1, 1600);
        end
        total++;
        if (hs_int !== 800) begin
            bad++; $display("FAIL mono_hs_period: got %0d expected 800", hs_int);
        end
        vreset = 1'b1;
        tick();
        vreset = 1'b0;
        measure_line(p, d, f, s);
        total++;
        if ({p, d, f, s} !== {32'sd800, 32'sd640, 32'sd16, 32'sd96}) begin
            bad++; $display("FAIL mono_line: got %0d/%0d/%0d/%0d expected 800/640/16/96", p, d, f, s);
        end
        total++;
        if (cyc_diff !== 0) begin
            bad++; $display("FAIL model_mono: %0d cycles differ, first at %0d got %h expected %h", cyc_diff, d_cyc, d_act, d_exp);
        end
    endtask

    task automatic test_back_to_back();
        cyc_diff = 0;
        repeat (37) tick();
        vreset = 1'b1;
        repeat (3) tick();
        vreset = 1'b0;
        tick();
        total++;
        if ({de, sof, x, y} !== {1'b1, 1'b1, 21'd0}) begin
            bad++; $display("FAIL b2b_restart: got de=%b sof=%b x=%0d y=%0d expected 1 1 0 0", de, sof, x, y);
        end
        tick();
        total++;
        if ({sof, x} !== {1'b0, 11'd1}) begin
            bad++; $display("FAIL b2b_next: got sof=%b x=%0d expected 0 1", sof, x);
        end
        total++;
        if (cyc_diff !== 0) begin
            bad++; $display("FAIL model_b2b: %0d cycles differ, first at %0d got %h expected %h", cyc_diff, d_cyc, d_act, d_exp);
        end
    endtask

    task automatic test_random();
        int r;
        cyc_diff = 0;
        for (int n = 0; n < 8000; n++) begin
            tick();
            r = $urandom_range(0, 999);
            vreset = (r < 6);
            reset  = (r == 777);
            if (r >= 990) mode = 2'($urandom_range(0, 3));
        end
        vreset = 1'b0;
        reset  = 1'b0;
        tick();
        total++;
        if (cyc_diff !== 0) begin
            bad++; $display("FAIL model_random: %0d cycles differ, first at %0d got %h expected %h", cyc_diff, d_cyc, d_act, d_exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        vreset = 1'b0;
        mode = 2'd1;
        test_reset();
        test_vreset_mid();
        test_mode_switch();
        test_mono_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
